vec_data_mem: RTL and testbench

VEC_DATA_MEM -- requirements
Module: vec_data_mem

---
 rtl/vec_data_mem.sv | 149 ++++++++++++++
 tb/tb_vec_data_mem.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_data_mem.sv
// vec_data_mem: 16-bank word-interleaved data memory, scalar or 16-lane
// vector access; unaligned vectors split across two cycles.
module vec_data_mem #(
  parameter int DEPTH_ROWS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_write,
  input  logic              vec_scalar,
  input  logic [17:0]       addr,
  input  logic [15:0][31:0] wdata,
  output logic [15:0][31:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              addr_err
);
  localparam int RW = (DEPTH_ROWS > 1) ? $clog2(DEPTH_ROWS) : 1;
  localparam logic [18:0] LIMIT = 19'(DEPTH_ROWS * 16);

  typedef enum logic {IDLE, SECOND} state_e;

  state_e            state_q, state_d;
  logic [17:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [15:0][31:0] wdata_q, wdata_d;
  logic [15:0][31:0] stage_q, stage_d;
  logic [15:0][31:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;

  logic              sec;
  logic [17:0]       a;
  logic              wr;
  logic [15:0][31:0] wd;
  logic [3:0]        off;
  logic [13:0]       r;
  logic [18:0]       last;
  logic              oor;
  logic              acc;
  logic              split;
  logic [15:0]       hi;
  logic [15:0]       bank_we;
  logic [3:0]        lane [16];
  logic [RW-1:0]     row  [16];
  logic [31:0]       bwd  [16];
  logic [31:0]       rd   [16];

  // Bank b carries element (b - off); banks below off belong to row r+1.
  always_comb begin
    sec   = (state_q == SECOND);
    a     = sec ? addr_q : addr;
    wr    = sec ? we_q : mem_write;
    wd    = sec ? wdata_q : wdata;
    off   = a[3:0];
    r     = a[17:4];
    last  = {1'b0, addr} + (vec_scalar ? 19'd15 : 19'd0);
    oor   = (last >= LIMIT);
    acc   = !sec && req_valid && !rst;
    split = acc && !oor && vec_scalar && (off != 4'd0);
    stall = split;
    for (int b = 0; b < 16; b++) begin
      hi[b]   = (4'(b) >= off);
      lane[b] = ~(4'(b) - off);
      bwd[b]  = wd[lane[b]];
      if (sec) begin
        row[b]     = RW'(r + 14'd1);
        bank_we[b] = !rst && wr && !hi[b];
      end else begin
        row[b]     = RW'(r);
        bank_we[b] = acc && !oor && wr &&
                     (vec_scalar ? hi[b] : (4'(b) == off));
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    stage_d  = stage_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = acc && oor;
    if (sec) begin
      state_d = IDLE;
      if (!we_q) begin
        rvalid_d = 1'b1;
        for (int b = 0; b < 16; b++) begin
          rdata_d[lane[b]] = hi[b] ? stage_q[lane[b]] : rd[b];
        end
      end
    end else if (split) begin
      state_d = SECOND;
      addr_d  = addr;
      we_d    = mem_write;
      wdata_d = wdata;
      if (!mem_write) begin
        stage_d = '0;
        for (int b = 0; b < 16; b++) begin
          if (hi[b]) stage_d[lane[b]] = rd[b];
        end
      end
    end else if (acc && !oor && !mem_write) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      for (int b = 0; b < 16; b++) begin
        if (vec_scalar || (4'(b) == off)) rdata_d[lane[b]] = rd[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      stage_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      stage_q  <= stage_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Bank contents survive reset.
  for (genvar g = 0; g < 16; g++) begin : g_bank
    logic [31:0] mem_q [DEPTH_ROWS];
    always_ff @(posedge clk) begin
      if (bank_we[g]) mem_q[row[g]] <= bwd[g];
    end
    assign rd[g] = mem_q[row[g]];
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_vec_data_mem.sv
// Testbench for vec_data_mem: directed and random scalar/vector traffic
// against a flat word-array model, checked by a queue-driven monitor.
`timescale 1ns/1ps
module tb_vec_data_mem;
  localparam int DEPTH_ROWS = 256;
  localparam int WORDS = DEPTH_ROWS * 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              mem_write;
  logic              vec_scalar;
  logic [17:0]       addr;
  logic [15:0][31:0] wdata;
  logic [15:0][31:0] rdata;
  logic              rdata_valid;
  logic              stall;
  logic              addr_err;

  vec_data_mem #(.DEPTH_ROWS(DEPTH_ROWS)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .mem_write(mem_write),
    .vec_scalar(vec_scalar),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .rdata_valid(rdata_valid),
    .stall(stall),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0][31:0] data;
    int                cyc;
  } ld_t;

  ld_t               ld_q[$];
  int                err_q[$];
  logic [31:0]       ref_mem [WORDS];
  logic [15:0][31:0] hold_exp = '0;
  int                cyc = 0;
  int                tests = 0;
  int                fails = 0;
  bit                mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok,
                     input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic rnd(output logic [15:0][31:0] d);
    for (int i = 0; i < 16; i++) d[i] = $urandom;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic issue(input bit w, input bit v, input logic [17:0] a,
                       input logic [15:0][31:0] d);
    bit  err;
    bit  split;
    int  n;
    int  cur;
    ld_t e;
    n     = v ? 16 : 1;
    err   = (int'(a) + n - 1) >= WORDS;
    split = v && !err && (a % 16 != 0);
    @(negedge clk);
    req_valid  = 1'b1;
    mem_write  = w;
    vec_scalar = v;
    addr       = a;
    wdata      = d;
    cur        = cyc;
    #1;
    chk("stall_accept", stall === split, stall, split);
    if (err) begin
      err_q.push_back(cur + 1);
    end else if (!w) begin
      e.data = '0;
      for (int i = 0; i < n; i++) e.data[15-i] = ref_mem[int'(a) + i];
      e.cyc = cur + (split ? 2 : 1);
      ld_q.push_back(e);
    end else begin
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = d[15-i];
    end
    @(posedge clk);
    if (split) begin
      @(negedge clk);
      #1;
      chk("stall_second", stall === 1'b0, stall, 1'b0);
      @(posedge clk);
    end
  endtask

  // Unaligned vector store abandoned by reset in its second cycle.
  task automatic split_store_reset(input logic [17:0] a,
                                   input logic [15:0][31:0] d);
    @(negedge clk);
    req_valid  = 1'b1;
    mem_write  = 1'b1;
    vec_scalar = 1'b1;
    addr       = a;
    wdata      = d;
    #1;
    chk("stall_accept_rst", stall === 1'b1, stall, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if ((int'(a) + i) / 16 == int'(a) / 16)
        ref_mem[int'(a) + i] = d[15-i];
    end
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    hold_exp = '0;
    #1;
    chk("stall_in_reset", stall === 1'b0, stall, 1'b0);
    @(posedge clk);
    #1;
    chk("addr_err_after_rst", addr_err === 1'b0, addr_err, 1'b0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    ld_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (rdata_valid === 1'b1) begin
          chk("rdata_valid_expected", ld_q.size() != 0, 1, ld_q.size());
          if (ld_q.size() != 0) begin
            e = ld_q.pop_front();
            chk("rdata", rdata === e.data, rdata, e.data);
            chk("load_latency", cyc == e.cyc, cyc, e.cyc);
            hold_exp = e.data;
          end
        end else begin
          chk("rdata_hold", rdata === hold_exp, rdata, hold_exp);
          if (ld_q.size() != 0 && ld_q[0].cyc < cyc) begin
            chk("rdata_valid_missing", 1'b0, cyc, ld_q[0].cyc);
            void'(ld_q.pop_front());
          end
        end
        if (addr_err === 1'b1) begin
          chk("addr_err_expected", err_q.size() != 0, 1, err_q.size());
          if (err_q.size() != 0) begin
            chk("addr_err_latency", cyc == err_q[0], cyc, err_q[0]);
            void'(err_q.pop_front());
          end
        end else if (err_q.size() != 0 && err_q[0] < cyc) begin
          chk("addr_err_missing", 1'b0, cyc, err_q[0]);
          void'(err_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [15:0][31:0] d;
    logic [17:0]       a;
    bit                w;
    bit                v;
    rst        = 1'b1;
    req_valid  = 1'b1;
    mem_write  = 1'b0;
    vec_scalar = 1'b1;
    addr       = 18'h25;
    wdata      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rdata", rdata === '0, rdata, 0);
    chk("rst_rdata_valid", rdata_valid === 1'b0, rdata_valid, 0);
    chk("rst_addr_err", addr_err === 1'b0, addr_err, 0);
    chk("rst_stall", stall === 1'b0, stall, 0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    mon_en    = 1'b1;

    for (int r = 0; r < 16; r++) begin
      rnd(d);
      issue(1'b1, 1'b1, 18'(r * 16), d);
    end
    for (int r = DEPTH_ROWS - 2; r < DEPTH_ROWS; r++) begin
      rnd(d);
      issue(1'b1, 1'b1, 18'(r * 16), d);
    end

    for (int i = 0; i < 16; i++) d[15-i] = 32'h100 + i;
    issue(1'b1, 1'b1, 18'h20, d);
    issue(1'b0, 1'b1, 18'h20, d);

    for (int i = 0; i < 16; i++) d[15-i] = 32'h20 + i;
    issue(1'b1, 1'b1, 18'h20, d);
    for (int i = 0; i < 16; i++) d[15-i] = 32'h30 + i;
    issue(1'b1, 1'b1, 18'h30, d);
    issue(1'b0, 1'b1, 18'h25, d);

    rnd(d);
    d[15] = 32'hDEADBEEF;
    issue(1'b1, 1'b0, 18'h7, d);
    issue(1'b0, 1'b0, 18'h7, d);

    issue(1'b0, 1'b1, 18'hFF1, d);
    issue(1'b0, 1'b0, 18'hFFF, d);
    issue(1'b0, 1'b1, 18'hFF0, d);
    issue(1'b0, 1'b0, 18'h1000, d);
    issue(1'b1, 1'b1, 18'h3FFF8, d);
    issue(1'b0, 1'b1, 18'hFE8, d);

    idle(2);
    rnd(d);
    split_store_reset(18'h48, d);
    issue(1'b0, 1'b1, 18'h40, d);
    issue(1'b0, 1'b1, 18'h50, d);
    issue(1'b0, 1'b1, 18'h48, d);

    issue(1'b0, 1'b1, 18'h60, d);
    rnd(d);
    issue(1'b1, 1'b1, 18'h60, d);
    issue(1'b0, 1'b1, 18'h60, d);

    repeat (300) begin
      w = $urandom_range(0, 1) == 1;
      v = $urandom_range(0, 2) != 0;
      case ($urandom_range(0, 7))
        0, 1:    a = 18'($urandom_range(12'hFE0, 13'h1008));
        2:       a = 18'($urandom);
        default: a = 18'(v ? $urandom_range(0, 8'hF0) : $urandom_range(0, 8'hFF));
      endcase
      rnd(d);
      issue(w, v, a, d);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    chk("ld_q_drained", ld_q.size() == 0, ld_q.size(), 0);
    chk("err_q_drained", err_q.size() == 0, err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
